// File: rtl/tea_pkg.sv
// Shared TEA definitions for the encrypt and decrypt datapaths.
//   ROUNDS / CNT_W : number of TEA rounds and the round-counter width
//   DELTA          : key-schedule constant added to the running sum each round
//   state_t        : control FSM encoding (IDLE / RUN / DONE)
//   K*_LSB, key_word : slicing of the 128-bit key into k0..k3
package tea_pkg;

  localparam int          ROUNDS = 32;
  localparam int          CNT_W  = $clog2(ROUNDS);
  localparam int          WORD_W = 32;
  localparam logic [31:0] DELTA  = 32'h9e37_79b9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // k0 sits in the least significant word of the key bus.
  localparam int K0_LSB = 0;
  localparam int K1_LSB = 32;
  localparam int K2_LSB = 64;
  localparam int K3_LSB = 96;

  function automatic logic [WORD_W-1:0] key_word(input logic [127:0] k, input int lsb);
    return k[lsb +: WORD_W];
  endfunction

endpackage

// File: rtl/encryptor_single_round.sv
// One combinational TEA encryption round, the mirror image of the decryptor round.
//   key      : 128-bit key (k0..k3)
//   inV0/inV1: block words entering the round
//   sum      : running sum for this round (DELTA * round number)
//   outputV0/outputV1 : block words leaving the round
module encryptor_single_round
  import tea_pkg::*;
(
  input  logic [127:0]      key,
  input  logic [WORD_W-1:0] inV0,
  input  logic [WORD_W-1:0] inV1,
  input  logic [WORD_W-1:0] sum,
  output logic [WORD_W-1:0] outputV0,
  output logic [WORD_W-1:0] outputV1
);

  logic [WORD_W-1:0] k0, k1, k2, k3;
  logic [WORD_W-1:0] nv0;

  // v1 is mixed with the freshly updated v0, not the incoming one.
  always_comb begin
    k0  = key_word(key, K0_LSB);
    k1  = key_word(key, K1_LSB);
    k2  = key_word(key, K2_LSB);
    k3  = key_word(key, K3_LSB);
    nv0 = inV0 + (((inV1 << 4) + k0) ^ (inV1 + sum) ^ ((inV1 >> 5) + k1));
    outputV0 = nv0;
    outputV1 = inV1 + (((nv0 << 4) + k2) ^ (nv0 + sum) ^ ((nv0 >> 5) + k3));
  end

endmodule

// File: rtl/seq_tea_encryptor.sv
// Iterative TEA block encryptor: one round per enabled clock, 32 rounds per block.
//   clk, rst (async, active-low), ena (clock enable, freezes all state)
//   in_valid / in_ready / inBlock64 / key : plaintext + key handshake
//   out_valid / out_ready / outBlock64    : registered ciphertext handshake
//   busy : high while rounds are being applied
// Block word mapping: V0 = [31:0], V1 = [63:32]; key k0 = [31:0] .. k3 = [127:96].
module seq_tea_encryptor
  import tea_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  inBlock64,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  outBlock64,
  output logic         busy
);

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   v0, v1, sum;
  logic [WORD_W-1:0]   rv0, rv1;
  logic [CNT_W-1:0]    cnt;
  logic [127:0]        key_q;
  logic                accept;
  logic                last_round;

  encryptor_single_round u_round (
    .key      (key_q),
    .inV0     (v0),
    .inV1     (v1),
    .sum      (sum),
    .outputV0 (rv0),
    .outputV1 (rv1)
  );

  assign last_round = (cnt == CNT_W'(ROUNDS - 1));
  assign accept     = in_ready && in_valid;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  // FSM next-state logic; DONE can hand straight over to a new block
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_round) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs; in_ready has a combinational path from out_ready
  always_comb begin
    in_ready  = ena && ((state == IDLE) || ((state == DONE) && out_ready));
    out_valid = (state == DONE);
    busy      = (state == RUN);
  end

  // Round datapath: accept loads the block, each RUN edge applies one round
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0         <= '0;
      v1         <= '0;
      sum        <= '0;
      cnt        <= '0;
      key_q      <= '0;
      outBlock64 <= '0;
    end else if (accept) begin
      v0    <= inBlock64[31:0];
      v1    <= inBlock64[63:32];
      key_q <= key;
      sum   <= DELTA;
      cnt   <= '0;
    end else if (ena && (state == RUN)) begin
      v0  <= rv0;
      v1  <= rv1;
      sum <= sum + DELTA;
      cnt <= cnt + CNT_W'(1);
      if (last_round) outBlock64 <= {rv1, rv0};
    end
  end

endmodule

// File: tb/tb_seq_tea_encryptor.sv
// Self-checking bench for seq_tea_encryptor: a software TEA model plus a
// transaction-level scoreboard checked every cycle, and directed scenarios.
module tb_seq_tea_encryptor;

  logic         clk = 1'b0;
  logic         rst, ena, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0]  inBlock64, outBlock64;
  logic [127:0] key;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  seq_tea_encryptor dut (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .inBlock64  (inBlock64),
    .key        (key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .outBlock64 (outBlock64),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain software TEA, straight from the algorithm definition.
  function automatic logic [63:0] tea_enc(input logic [63:0] b, input logic [127:0] k);
    logic [31:0] a0, a1, s;
    a0 = b[31:0]; a1 = b[63:32]; s = 32'd0;
    for (int r = 0; r < 32; r++) begin
      s  = s + 32'h9e3779b9;
      a0 = a0 + (((a1 << 4) + k[31:0]) ^ (a1 + s) ^ ((a1 >> 5) + k[63:32]));
      a1 = a1 + (((a0 << 4) + k[95:64]) ^ (a0 + s) ^ ((a0 >> 5) + k[127:96]));
    end
    return {a1, a0};
  endfunction

  function automatic logic [63:0] tea_dec(input logic [63:0] b, input logic [127:0] k);
    logic [31:0] a0, a1, s;
    a0 = b[31:0]; a1 = b[63:32]; s = 32'hc6ef3720;
    for (int r = 0; r < 32; r++) begin
      a1 = a1 - (((a0 << 4) + k[95:64]) ^ (a0 + s) ^ ((a0 >> 5) + k[127:96]));
      a0 = a0 - (((a1 << 4) + k[31:0]) ^ (a1 + s) ^ ((a1 >> 5) + k[63:32]));
      s  = s - 32'h9e3779b9;
    end
    return {a1, a0};
  endfunction

  // Transaction-level scoreboard: a block in flight needs 32 enabled edges,
  // then waits for out_ready; results are computed by tea_enc at accept time.
  int           m_left = 0;
  bit           m_have = 1'b0;
  logic [63:0]  m_out = '0, m_ct = '0, m_pt = '0;
  logic [127:0] m_key = '0;
  int           n_delivered = 0;

  always @(negedge clk) begin
    bit exp_ir, acc;
    if (!rst) begin
      m_left = 0;
      m_have = 1'b0;
      m_out  = '0;
    end
    exp_ir = ena && (m_left == 0) && (!m_have || out_ready);
    check("out_valid", {63'd0, out_valid}, {63'd0, m_have});
    check("busy", {63'd0, busy}, {63'd0, (m_left != 0)});
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
    check("outBlock64", outBlock64, m_out);
    if (m_have && out_valid) check("roundtrip", tea_dec(outBlock64, m_key), m_pt);
    if (rst && ena) begin
      acc = in_valid && exp_ir;
      if (m_have && out_ready) begin
        m_have = 1'b0;
        n_delivered++;
      end
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_have = 1'b1;
          m_out  = m_ct;
        end
      end else if (acc) begin
        m_ct   = tea_enc(inBlock64, key);
        m_pt   = inBlock64;
        m_key  = key;
        m_left = 32;
      end
    end
  end

  task automatic send(input logic [63:0] b, input logic [127:0] k);
    int n;
    n = 0;
    @(posedge clk); #1;
    inBlock64 = b; key = k; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts rising edges since the accept edge until out_valid shows.
  task automatic wait_done(input int start, output int lat);
    lat = start;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid && lat < 300);
  endtask

  task automatic burst(input int n, input bit spacing);
    int acc, last, guard, d0;
    acc = 0; last = -1; guard = 0; d0 = n_delivered;
    @(posedge clk); #1;
    inBlock64 = {$urandom, $urandom};
    key = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1; out_ready = 1'b1;
    while (acc < n && guard < n * 40 + 100) begin
      @(negedge clk);
      guard++;
      if (in_ready) begin
        if (spacing && last >= 0) check("b2b_spacing", 64'(cyc - last), 64'd33);
        last = cyc;
        acc++;
        @(posedge clk); #1;
        inBlock64 = {$urandom, $urandom};
        key = {$urandom, $urandom, $urandom, $urandom};
        if (acc == n) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("burst_accepts", 64'(acc), 64'(n));
    guard = 0;
    while ((n_delivered - d0) < n && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("burst_delivered", 64'(n_delivered - d0), 64'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0]  b, exp;
    logic [127:0] k;
    int           lat, nv;

    rst = 1'b0; ena = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    inBlock64 = '0; key = '0;

    // Pin the software model to known values.
    check("model_zero", tea_enc(64'd0, 128'd0), 64'h94baa940_41ea3a0a);
    check("model_inverse",
          tea_dec(tea_enc(64'h0123456789abcdef, 128'h00112233_44556677_8899aabb_ccddeeff),
                  128'h00112233_44556677_8899aabb_ccddeeff),
          64'h0123456789abcdef);

    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_out", outBlock64, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; ena = 1'b1; out_ready = 1'b1;

    // Zero vector: 32-cycle latency, single out_valid cycle.
    send(64'd0, 128'd0);
    wait_done(0, lat);
    check("zero_latency", 64'(lat), 64'd32);
    check("zero_ct", outBlock64, 64'h94baa940_41ea3a0a);
    nv = 1;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("zero_single_valid", 64'(nv), 64'd1);

    // ena low for 5 cycles mid-run delays completion by exactly 5.
    b = 64'hdeadbeef_cafef00d; k = 128'h01234567_89abcdef_fedcba98_76543210;
    send(b, k);
    repeat (10) @(posedge clk);
    #1 ena = 1'b0;
    repeat (5) @(posedge clk);
    #1 ena = 1'b1;
    wait_done(15, lat);
    check("stall_latency", 64'(lat), 64'd37);
    check("stall_ct", outBlock64, tea_enc(b, k));

    // Backpressure: hold in DONE for 10 cycles.
    @(posedge clk); #1 out_ready = 1'b0;
    b = 64'h00000001_00000002; k = 128'h1;
    exp = tea_enc(b, k);
    send(b, k);
    wait_done(0, lat);
    check("bp_latency", 64'(lat), 64'd32);
    repeat (10) begin
      @(negedge clk);
      check("bp_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_data", outBlock64, exp);
    end
    @(posedge clk); #1 out_ready = 1'b1;

    // Disturb inputs while running: result belongs to the original block.
    b = 64'h11112222_33334444; k = 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd;
    send(b, k);
    repeat (5) @(posedge clk);
    #1 key = ~k; inBlock64 = ~b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_done(6, lat);
    check("disturb_latency", 64'(lat), 64'd32);
    check("disturb_ct", outBlock64, tea_enc(b, k));

    // Reset after 17 rounds discards the block.
    send(64'h55555555_aaaaaaaa, 128'h9);
    repeat (17) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_out", outBlock64, 64'd0);
    @(posedge clk); #1 rst = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    check("midrst_no_valid", 64'(nv), 64'd0);
    b = 64'hfeedface_0badf00d; k = 128'h31415926_53589793_23846264_33832795;
    send(b, k);
    wait_done(0, lat);
    check("after_rst_latency", 64'(lat), 64'd32);
    check("after_rst_ct", outBlock64, tea_enc(b, k));

    // Back-to-back blocks, then the random regression.
    burst(4, 1'b1);
    burst(1000, 1'b0);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
